// File: rtl/alu_seq_unit.sv
// Chunk-serial add/subtract responder with valid/ready request and response handshakes.
// Optional status flags (zero, carry, signed overflow) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_seq_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic             alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
`endif
);

  localparam int CYCLES = WIDTH / CHUNK;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;
  logic             last_chunk;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, zero_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic msb_cin;
`endif

  // Current chunk, with B inverted for subtract; the +1 comes from the preset carry.
  assign a_chunk    = a_q[count_q*CHUNK +: CHUNK];
  assign b_eff      = op_q ? ~b_q[count_q*CHUNK +: CHUNK] : b_q[count_q*CHUNK +: CHUNK];
  assign sum        = {1'b0, a_chunk} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (count_q == CNT_W'(CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      res_q      <= '0;
      out_data_q <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    carry_d    = carry_q;
    count_d    = count_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d     = zero_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    msb_cin    = sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_eff[CHUNK-1];
`endif

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_data1;
          b_d     = in_data2;
          op_d    = alu_op;
          carry_d = alu_op;
          count_d = '0;
          res_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d[count_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        count_d = count_q + 1'b1;
        // The result only becomes visible once every chunk is done.
        if (last_chunk) begin
          count_d    = '0;
          out_data_d = res_d;
          state_d    = DONE;
`ifdef ALU_SEQ_FLAGS_EN
          zero_d     = (res_d == '0);
          cout_d     = sum[CHUNK];
          ovf_d      = msb_cin ^ sum[CHUNK];
`endif
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_data = out_data_q;

`ifdef ALU_SEQ_FLAGS_EN
  assign flag_zero  = zero_q;
  assign flag_carry = cout_q;
  assign flag_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised self-checking bench for alu_seq_unit against an arithmetic reference model.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq_unit;

  localparam int W      = 16;
  localparam int CYCLES = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data1;
  logic [W-1:0] in_data2;
  logic         alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef ALU_SEQ_FLAGS_EN
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_zero (flag_zero),
    .flag_carry(flag_carry),
    .flag_ovf  (flag_ovf)
`endif
  );

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic op);
    int unsigned r;
    r = op ? (int'(a) - int'(b) + 65536) : (int'(a) + int'(b));
    return W'(r % 65536);
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    return op ? (a >= b) : ((int'(a) + int'(b)) > 65535);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = op ? sa - sb : sa + sb;
    return (r > 32767) || (r < -32768);
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, output bit to);
    int n;
    in_data1 = a;
    in_data2 = b;
    alu_op   = op;
    in_valid = 1'b1;
    n  = 0;
    to = 1'b0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) to = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid is seen.
  task automatic wait_result(output logic [W-1:0] res, output int edges, output bit to);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    to  = !out_valid;
    res = out_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data1 = '0; in_data2 = '0; alu_op = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h required 1 0 0000", in_ready, out_valid, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: in_ready=%b out_valid=%b out_data=%h", in_ready, out_valid, out_data);
  endtask

  task automatic test_add();
    logic [W-1:0] res, exp;
    int edges;
    bit to;
    exp = ref_result(16'd836, 16'd112, 1'b0);
    issue(16'd836, 16'd112, 1'b0, to);
    wait_result(res, edges, to);
    checks++;
    if (to || res !== exp || edges != CYCLES) begin
      errors++;
      $display("FAIL add: data=%0d edges=%0d timeout=%0b required data=%0d edges=%0d", res, edges, to, exp, CYCLES);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL add_hold: out_valid=%b data=%0d required 1 %0d", out_valid, out_data, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== exp) begin
      errors++;
      $display("FAIL add_drop: out_valid=%b data=%0d required 0 %0d", out_valid, out_data, exp);
    end
    $display("add: 836+112 -> %0d after %0d edges", res, edges);
  endtask

  task automatic test_sub();
    logic [W-1:0] a_tab [2] = '{16'd1427, 16'd17};
    logic [W-1:0] b_tab [2] = '{16'd201, 16'd19};
    logic [W-1:0] res, exp;
    int edges;
    bit to;
    for (int i = 0; i < 2; i++) begin
      exp = ref_result(a_tab[i], b_tab[i], 1'b1);
      issue(a_tab[i], b_tab[i], 1'b1, to);
      wait_result(res, edges, to);
      checks++;
      if (to || res !== exp) begin
        errors++;
        $display("FAIL sub: %0d-%0d data=%h timeout=%0b required %h", a_tab[i], b_tab[i], res, to, exp);
      end
`ifdef ALU_SEQ_FLAGS_EN
      checks++;
      if (flag_carry !== ref_carry(a_tab[i], b_tab[i], 1'b1)) begin
        errors++;
        $display("FAIL sub_carry: flag_carry=%b required %b", flag_carry, ref_carry(a_tab[i], b_tab[i], 1'b1));
      end
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      $display("sub: %0d-%0d -> %h", a_tab[i], b_tab[i], res);
    end
  endtask

  task automatic test_operand_hold();
    logic [W-1:0] res, na, nb, exp2;
    logic nop;
    int edges;
    bit to;
    na = W'($urandom); nb = W'($urandom); nop = 1'($urandom);
    exp2 = ref_result(na, nb, nop);
    issue(16'd114, 16'd514, 1'b0, to);
    in_data1 = na; in_data2 = nb; alu_op = nop; in_valid = 1'b1;
    edges = 0;
    while (!out_valid && edges < 50) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready_calc: in_ready=%b required 0", in_ready);
      end
      @(negedge clk);
      edges++;
    end
    checks++;
    if (!out_valid || in_ready !== 1'b0 || out_data !== 16'd628) begin
      errors++;
      $display("FAIL hold_done: out_valid=%b in_ready=%b data=%0d required 1 0 628", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_idle: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(res, edges, to);
    checks++;
    if (to || res !== exp2) begin
      errors++;
      $display("FAIL hold_second: data=%h timeout=%0b required %h", res, to, exp2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("operand_hold: first=628 second=%h", res);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] qa [3] = '{16'd300, 16'd300, 16'd5};
    logic [W-1:0] qb [3] = '{16'd45, 16'd45, 16'd9};
    logic         qo [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] exp_q [$];
    int accept_t [$];
    int idx, got;
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_result(qa[i], qb[i], qo[i]));
    out_ready = 1'b1;
    idx = 0; got = 0;
    in_data1 = qa[0]; in_data2 = qb[0]; alu_op = qo[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      if (out_valid) begin
        checks++;
        if (out_data !== exp_q[got]) begin
          errors++;
          $display("FAIL b2b_data[%0d]: data=%h required %h", got, out_data, exp_q[got]);
        end
        $display("b2b: result %0d = %h at cycle %0d", got, out_data, cyc);
        got++;
      end
      if (in_ready && in_valid) begin
        accept_t.push_back(cyc);
        idx++;
      end
      @(negedge clk);
      if (idx < 3) begin
        in_data1 = qa[idx]; in_data2 = qb[idx]; alu_op = qo[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 3 || accept_t.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: results=%0d accepts=%0d required 3 3", got, accept_t.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (accept_t[i] - accept_t[i-1] != CYCLES + 2) begin
          errors++;
          $display("FAIL b2b_interval: %0d required %0d", accept_t[i] - accept_t[i-1], CYCLES + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res;
    int edges;
    bit to;
    issue(16'd836, 16'd112, 1'b0, to);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b data=%h required 1 0 0000", in_ready, out_valid, out_data);
    end
    issue(16'd17, 16'd19, 1'b0, to);
    wait_result(res, edges, to);
    checks++;
    if (to || res !== 16'd36 || edges != CYCLES) begin
      errors++;
      $display("FAIL reset_mid_next: data=%0d edges=%0d required 36 %0d", res, edges, CYCLES);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("reset_mid: after reset 17+19 -> %0d", res);
  endtask

`ifdef ALU_SEQ_FLAGS_EN
  task automatic test_flags();
    logic [W-1:0] a_tab [2] = '{16'h7FFF, 16'd5};
    logic [W-1:0] b_tab [2] = '{16'h0001, 16'd5};
    logic         o_tab [2] = '{1'b0, 1'b1};
    logic [W-1:0] res, exp;
    int edges;
    bit to;
    for (int i = 0; i < 2; i++) begin
      exp = ref_result(a_tab[i], b_tab[i], o_tab[i]);
      issue(a_tab[i], b_tab[i], o_tab[i], to);
      wait_result(res, edges, to);
      checks++;
      if (to || res !== exp || flag_zero !== (exp == '0) ||
          flag_carry !== ref_carry(a_tab[i], b_tab[i], o_tab[i]) ||
          flag_ovf !== ref_ovf(a_tab[i], b_tab[i], o_tab[i])) begin
        errors++;
        $display("FAIL flags: data=%h z=%b c=%b v=%b required %h %b %b %b", res, flag_zero, flag_carry, flag_ovf,
                 exp, (exp == '0), ref_carry(a_tab[i], b_tab[i], o_tab[i]), ref_ovf(a_tab[i], b_tab[i], o_tab[i]));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      $display("flags: %h op%0b %h -> %h", a_tab[i], o_tab[i], b_tab[i], res);
    end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] a, b, res, exp;
    logic op;
    int edges, hold;
    bit to;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      if (i < 4) b = a;
      exp = ref_result(a, b, op);
      issue(a, b, op, to);
      wait_result(res, edges, to);
      checks++;
      if (to || res !== exp || edges != CYCLES) begin
        errors++;
        $display("FAIL rand[%0d]: %h op%0b %h data=%h edges=%0d required %h %0d", i, a, op, b, res, edges, exp, CYCLES);
      end
`ifdef ALU_SEQ_FLAGS_EN
      checks++;
      if (flag_zero !== (exp == '0) || flag_carry !== ref_carry(a, b, op) || flag_ovf !== ref_ovf(a, b, op)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: z=%b c=%b v=%b required %b %b %b", i, flag_zero, flag_carry, flag_ovf,
                 (exp == '0), ref_carry(a, b, op), ref_ovf(a, b, op));
      end
`endif
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL rand_hold[%0d]: out_valid=%b data=%h required 1 %h", i, out_valid, out_data, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      $display("rand[%0d]: %h op%0b %h -> %h hold=%0d", i, a, op, b, res, hold);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_operand_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_SEQ_FLAGS_EN
    test_flags();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
